// File: rtl/tri_pkg.sv
// Shared types and constants for the point-in-triangle classifier.
// Holds the triangle table, the vertex record and the FSM encoding.
package tri_pkg;

  localparam int COORD_W_DEF = 11;
  localparam int N_TBL = 5;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] ax;
    logic [COORD_W_DEF-1:0] ay;
    logic [COORD_W_DEF-1:0] bx;
    logic [COORD_W_DEF-1:0] by;
    logic [COORD_W_DEF-1:0] cx;
    logic [COORD_W_DEF-1:0] cy;
  } tri_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_TEST,
    S_DONE
  } state_t;

  localparam tri_t TRI_TABLE [N_TBL] = '{
    '{11'd82,  11'd104, 11'd171, 11'd322, 11'd321, 11'd69},
    '{11'd80,  11'd470, 11'd80,  11'd352, 11'd242, 11'd352},
    '{11'd301, 11'd458, 11'd480, 11'd458, 11'd389, 11'd344},
    '{11'd290, 11'd259, 11'd413, 11'd289, 11'd364, 11'd166},
    '{11'd612, 11'd227, 11'd493, 11'd241, 11'd442, 11'd76}
  };

endpackage

// File: rtl/tri_hit_tester_if.sv
// Point-in / result-out handshake bundle for tri_hit_tester.
// master drives points and accepts results; slave is the classifier.
interface tri_hit_tester_if
  import tri_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int N_TRI   = 5
);
  localparam int IDX_W = (N_TRI > 1) ? $clog2(N_TRI) : 1;

  logic               pt_valid;
  logic               pt_ready;
  logic [COORD_W-1:0] pt_x;
  logic [COORD_W-1:0] pt_y;
  logic               res_valid;
  logic               res_ready;
  logic [N_TRI-1:0]   res_mask;
  logic [IDX_W:0]     res_count;

  modport master (
    output pt_valid, pt_x, pt_y, res_ready,
    input  pt_ready, res_valid, res_mask, res_count
  );

  modport slave (
    input  pt_valid, pt_x, pt_y, res_ready,
    output pt_ready, res_valid, res_mask, res_count
  );
endinterface

// File: rtl/tri_rom.sv
// Synchronous one-cycle triangle table read.
// Addresses past the table return all-zero (degenerate) vertices.
module tri_rom
  import tri_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output tri_t          data
);

  tri_t rd;

  always_comb begin
    rd = '0;
    for (int i = 0; i < N_TBL; i++) begin
      if (int'(addr) == i) rd = TRI_TABLE[i];
    end
  end

  always_ff @(posedge clk) begin
    data <= rd;
  end

endmodule

// File: rtl/tri_hit_tester.sv
// Streaming point-in-triangle classifier, one triangle per clock.
// Define TRI_EDGE_INCL_EN to count edge/vertex points as inside.
module tri_hit_tester
  import tri_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int N_TRI   = 5
) (
  input logic            clk,
  input logic            rst,
  tri_hit_tester_if.slave bus
);

  localparam int IDX_W = (N_TRI > 1) ? $clog2(N_TRI) : 1;
  localparam int AW    = IDX_W + 1;
  localparam int EW    = 2 * COORD_W + 3;

  typedef logic [COORD_W-1:0] crd_t;
  typedef logic signed [EW-1:0] e_t;

  state_t           state;
  state_t           state_nx;
  crd_t             px;
  crd_t             py;
  logic [AW-1:0]    rom_addr;
  logic [IDX_W-1:0] idx;
  logic [N_TRI-1:0] mask;
  logic [N_TRI-1:0] mask_nx;
  logic [IDX_W:0]   count;
  tri_t             rom_data;
  logic             accept;
  logic             last;
  logic             hit;
  crd_t             ax, ay, bx, by, cx, cy;
  e_t               d1, d2, d3, area;

  tri_rom #(.AW(AW)) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  function automatic e_t edge_fn(
    crd_t ux, crd_t uy, crd_t vx, crd_t vy, crd_t wx, crd_t wy
  );
    logic signed [COORD_W:0] dxu, dyv, dxv, dyu;
    dxu = $signed({1'b0, ux}) - $signed({1'b0, wx});
    dyv = $signed({1'b0, vy}) - $signed({1'b0, wy});
    dxv = $signed({1'b0, vx}) - $signed({1'b0, wx});
    dyu = $signed({1'b0, uy}) - $signed({1'b0, wy});
    return EW'(dxu) * EW'(dyv) - EW'(dxv) * EW'(dyu);
  endfunction

  function automatic logic [IDX_W:0] popcnt(logic [N_TRI-1:0] m);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < N_TRI; i++) c = c + (IDX_W+1)'(m[i]);
    return c;
  endfunction

  always_comb begin
    ax = COORD_W'(rom_data.ax);
    ay = COORD_W'(rom_data.ay);
    bx = COORD_W'(rom_data.bx);
    by = COORD_W'(rom_data.by);
    cx = COORD_W'(rom_data.cx);
    cy = COORD_W'(rom_data.cy);
    d1   = edge_fn(ax, ay, bx, by, px, py);
    d2   = edge_fn(bx, by, cx, cy, px, py);
    d3   = edge_fn(cx, cy, ax, ay, px, py);
    area = edge_fn(ax, ay, bx, by, cx, cy);
`ifdef TRI_EDGE_INCL_EN
    hit = (area != '0) &&
          ((!d1[EW-1] && !d2[EW-1] && !d3[EW-1]) ||
           ((d1[EW-1] || d1 == '0) &&
            (d2[EW-1] || d2 == '0) &&
            (d3[EW-1] || d3 == '0)));
`else
    hit = (area != '0) &&
          ((!d1[EW-1] && d1 != '0 &&
            !d2[EW-1] && d2 != '0 &&
            !d3[EW-1] && d3 != '0) ||
           (d1[EW-1] && d2[EW-1] && d3[EW-1]));
`endif
  end

  assign last = (idx == IDX_W'(N_TRI - 1));

  always_comb begin
    mask_nx = mask;
    for (int i = 0; i < N_TRI; i++) begin
      if (idx == IDX_W'(i)) mask_nx[i] = hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.pt_ready  = 1'b0;
    bus.res_valid = 1'b0;
    accept        = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.pt_ready = !rst;
        accept       = bus.pt_valid && !rst;
        if (accept) state_nx = S_FETCH;
      end
      S_FETCH: state_nx = S_TEST;
      S_TEST: begin
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // rom_addr leads idx by one so ROM data lines up with the TEST cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      px       <= '0;
      py       <= '0;
      rom_addr <= '0;
      idx      <= '0;
      mask     <= '0;
      count    <= '0;
    end else begin
      if (accept) begin
        px       <= bus.pt_x;
        py       <= bus.pt_y;
        rom_addr <= '0;
        idx      <= '0;
        mask     <= '0;
        count    <= '0;
      end
      if (state == S_FETCH) rom_addr <= AW'(1);
      if (state == S_TEST) begin
        mask     <= mask_nx;
        rom_addr <= rom_addr + AW'(1);
        if (last) count <= popcnt(mask_nx);
        else      idx   <= idx + IDX_W'(1);
      end
    end
  end

  assign bus.res_mask  = mask;
  assign bus.res_count = count;

endmodule

// File: tb/tb_tri_hit_tester.sv
// Directed and golden-model bench for tri_hit_tester.
// Inputs change and outputs are sampled on the falling edge.
module tb_tri_hit_tester;
  import tri_pkg::*;

  localparam int NR = 1000;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_pass;

  int T [5][6] = '{
    '{82, 104, 171, 322, 321, 69},
    '{80, 470, 80, 352, 242, 352},
    '{301, 458, 480, 458, 389, 344},
    '{290, 259, 413, 289, 364, 166},
    '{612, 227, 493, 241, 442, 76}
  };

  tri_hit_tester_if #(.COORD_W(11), .N_TRI(5)) bus ();

  tri_hit_tester #(.COORD_W(11), .N_TRI(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic longint ef(longint ux, longint uy, longint vx,
                                longint vy, longint wx, longint wy);
    return (ux - wx) * (vy - wy) - (vx - wx) * (uy - wy);
  endfunction

  function automatic logic [4:0] gold(int px, int py);
    logic [4:0] m;
    longint a, b, c, ar;
    logic pos, neg;
    m = '0;
    for (int i = 0; i < 5; i++) begin
      a  = ef(T[i][0], T[i][1], T[i][2], T[i][3], px, py);
      b  = ef(T[i][2], T[i][3], T[i][4], T[i][5], px, py);
      c  = ef(T[i][4], T[i][5], T[i][0], T[i][1], px, py);
      ar = ef(T[i][0], T[i][1], T[i][2], T[i][3], T[i][4], T[i][5]);
`ifdef TRI_EDGE_INCL_EN
      pos = (a >= 0) && (b >= 0) && (c >= 0);
      neg = (a <= 0) && (b <= 0) && (c <= 0);
`else
      pos = (a > 0) && (b > 0) && (c > 0);
      neg = (a < 0) && (b < 0) && (c < 0);
`endif
      m[i] = (ar != 0) && (pos || neg);
    end
    return m;
  endfunction

  task automatic put_pt(input int x, input int y, output int acc);
    int n;
    n = 0;
    bus.pt_valid = 1'b1;
    bus.pt_x = 11'(x);
    bus.pt_y = 11'(y);
    while (!bus.pt_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'd0, bus.pt_ready}, 32'd1);
    acc = cyc;
    @(negedge clk);
    bus.pt_valid = 1'b0;
  endtask

  task automatic wait_res(output int t);
    int n;
    n = 0;
    while (!bus.res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("res_timeout", {31'd0, bus.res_valid}, 32'd1);
    t = cyc;
  endtask

  task automatic take_res;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_drop", {31'd0, bus.res_valid}, 32'd0);
  endtask

  task automatic do_point(input string tag, input int x, input int y,
                          input logic [4:0] em, input int ec);
    int acc, t;
    put_pt(x, y, acc);
    wait_res(t);
    check({tag, "_lat"}, t - acc, 32'd7);
    check({tag, "_mask"}, {27'd0, bus.res_mask}, {27'd0, em});
    check({tag, "_cnt"}, {28'd0, bus.res_count}, ec);
    take_res();
  endtask

  initial begin
    int acc, t, prev, sent, got, x, y, stale;
    logic [31:0] e;
    logic [4:0] q [$];
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.pt_valid = 1'b0;
    bus.pt_x = '0;
    bus.pt_y = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pt_ready", {31'd0, bus.pt_ready}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_mask", {27'd0, bus.res_mask}, 32'd0);
    check("rst_count", {28'd0, bus.res_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, bus.pt_ready}, 32'd1);

    do_point("p100_400", 100, 400, 5'b00010, 1);
    do_point("p191_165", 191, 165, 5'b00001, 1);
    do_point("p515_181", 515, 181, 5'b10000, 1);
    do_point("p0_0", 0, 0, 5'b00000, 0);
`ifdef TRI_EDGE_INCL_EN
    do_point("edge80_400", 80, 400, 5'b00010, 1);
`else
    do_point("edge80_400", 80, 400, 5'b00000, 0);
`endif

    // backpressure with a competing point offered
    put_pt(100, 400, acc);
    wait_res(t);
    bus.pt_valid = 1'b1;
    bus.pt_x = 11'd191;
    bus.pt_y = 11'd165;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, bus.res_valid}, 32'd1);
      check("bp_mask", {27'd0, bus.res_mask}, 32'h2);
      check("bp_ready", {31'd0, bus.pt_ready}, 32'd0);
    end
    bus.pt_valid = 1'b0;
    take_res();
    check("bp_idle", {31'd0, bus.pt_ready}, 32'd1);
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.res_valid) stale = 1;
    end
    check("bp_not_consumed", stale, 32'd0);

    // reset while testing triangle 2
    put_pt(100, 400, acc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus.res_valid}, 32'd0);
    check("mid_rst_mask", {27'd0, bus.res_mask}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.pt_ready}, 32'd1);
    stale = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.res_valid) stale = 1;
    end
    check("mid_rst_stale", stale, 32'd0);

    // back-to-back random points
    bus.res_ready = 1'b1;
    x = 0;
    y = 0;
    bus.pt_valid = 1'b1;
    bus.pt_x = '0;
    bus.pt_y = '0;
    prev = -1;
    sent = 0;
    got = 0;
    for (int k = 0; k < 12000 && got < NR; k++) begin
      if (bus.res_valid) begin
        if (q.size() > 0) e = {27'd0, q.pop_front()};
        else e = 32'hFFFF_FFFF;
        check("b2b_mask", {27'd0, bus.res_mask}, e);
        check("b2b_cnt", {28'd0, bus.res_count}, $countones(e));
        got++;
      end
      if (bus.pt_valid && bus.pt_ready) begin
        if (prev >= 0) check("b2b_gap", cyc - prev, 32'd8);
        prev = cyc;
        q.push_back(gold(x, y));
        sent++;
        @(posedge clk);
        #1;
        if (sent < NR) begin
          x = (sent % 4 == 0) ? int'($urandom_range(0, 2047))
                              : int'($urandom_range(40, 640));
          y = (sent % 4 == 0) ? int'($urandom_range(0, 2047))
                              : int'($urandom_range(40, 500));
          bus.pt_x = 11'(x);
          bus.pt_y = 11'(y);
        end else begin
          bus.pt_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b_all_results", got, NR);
    bus.res_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
